// File: rtl/display_pkg.sv
// Shared codes, scan-state encoding and the leading-zero blanking helper
// for the seven-segment scan controller.
package display_pkg;

    localparam logic [3:0] CODE_ZERO  = 4'd0;
    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Widest digit row the blanking helper can examine.
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } scan_state_t;

    // One bit of the leading-zero blank mask: digit idx is blanked when it
    // holds 0, is not the least significant digit, and every more
    // significant digit (below n) is 0 or blank. A dash is significant.
    function automatic logic lead_zero_blank(input logic [4*MAX_DIGITS-1:0] digits,
                                             input int idx,
                                             input int n);
        logic lead;
        logic blank;
        lead  = 1'b1;
        blank = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if ((i < n) && (i > idx)) begin
                if ((digits[4*i +: 4] != CODE_ZERO) && (digits[4*i +: 4] != CODE_BLANK)) begin
                    lead = 1'b0;
                end else begin
                    lead = lead;
                end
            end else begin
                lead = lead;
            end
        end
        if ((idx > 0) && (idx < n) && lead && (digits[4*idx +: 4] == CODE_ZERO)) begin
            blank = 1'b1;
        end else begin
            blank = 1'b0;
        end
        return blank;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Bus between the calculator core (master) and the scan controller (slave),
// carrying both the digit-update side and the decoder/anode side.
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   point_in;
    logic [3:0]              code_out;
    logic                    show_point_out;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic [SEL_W-1:0]        digit_sel;
    logic                    frame_done;

    modport master (
        output enable, load, digits_in, point_in,
        input  code_out, show_point_out, anode_n, digit_sel, frame_done
    );

    modport slave (
        input  enable, load, digits_in, point_in,
        output code_out, show_point_out, anode_n, digit_sel, frame_done
    );
endinterface

// File: rtl/display_scan_controller_refresh_timer.sv
// Slot counter for one digit period: counts 0..REFRESH_DIV-1 while run is
// high and flags the guard interval and the slot's last cycle.
module refresh_timer #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic in_guard,
    output logic guard_end,
    output logic slot_end
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
    localparam logic [CNT_W-1:0] GUARD_LST = CNT_W'(GUARD - 1);

    logic [CNT_W-1:0] r_cnt;

    // Slot counter: cleared whenever scanning stops, wraps at the slot end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!run) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign in_guard  = (r_cnt < GUARD_CNT);
    assign guard_end = (r_cnt == GUARD_LST);
    assign slot_end  = (r_cnt == LAST_CNT);

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed seven-segment scan controller: shadow/active digit registers
// for tear-free updates, leading-zero blanking and anode guard intervals.
// Output registers are loaded from next-state values so every output lines
// up with the state held in the same cycle.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int GUARD         = 16,
    parameter int BLANK_LEADING = 1
) (
    input logic clk,
    input logic rst_n,
    display_scan_controller_if.slave bus
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    scan_state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]        r_sel, w_sel_nxt;
    logic [4*NUM_DIGITS-1:0] r_shadow, r_active, w_active_nxt;
    logic [NUM_DIGITS-1:0]   r_shadow_pt, r_active_pt, w_active_pt_nxt;
    logic                    r_pending;
    logic                    w_run, w_in_guard, w_guard_end, w_slot_end, w_wrap;
    logic [4*MAX_DIGITS-1:0] w_ext;
    logic [NUM_DIGITS-1:0]   w_mask;
    logic [3:0]              w_code_nxt;
    logic                    w_point_nxt;
    logic [NUM_DIGITS-1:0]   w_anode_nxt;
    logic [3:0]              r_code;
    logic                    r_point;
    logic [NUM_DIGITS-1:0]   r_anode_n;
    logic                    r_frame_done;

    assign w_run  = bus.enable && (r_state != S_IDLE);
    assign w_wrap = w_run && (r_state == S_ON) && w_slot_end && (r_sel == LAST_SEL);

    refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (w_run),
        .in_guard  (w_in_guard),
        .guard_end (w_guard_end),
        .slot_end  (w_slot_end)
    );

    // Next scan state and digit index.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        if (!bus.enable) begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_GUARD;
                    w_sel_nxt   = '0;
                end
                S_GUARD: begin
                    if (w_in_guard && !w_guard_end) begin
                        w_state_nxt = S_GUARD;
                    end else begin
                        w_state_nxt = S_ON;
                    end
                end
                S_ON: begin
                    if (w_slot_end) begin
                        w_state_nxt = S_GUARD;
                        w_sel_nxt   = (r_sel == LAST_SEL) ? '0 : (r_sel + SEL_W'(1));
                    end else begin
                        w_state_nxt = S_ON;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_sel_nxt   = '0;
                end
            endcase
        end
    end

    // Active digits: commit at the frame wrap (a coincident load goes straight
    // in) or, while idle, as soon as a pending shadow exists.
    always_comb begin
        w_active_nxt    = r_active;
        w_active_pt_nxt = r_active_pt;
        if (w_wrap) begin
            if (bus.load) begin
                w_active_nxt    = bus.digits_in;
                w_active_pt_nxt = bus.point_in;
            end else if (r_pending) begin
                w_active_nxt    = r_shadow;
                w_active_pt_nxt = r_shadow_pt;
            end else begin
                w_active_nxt    = r_active;
                w_active_pt_nxt = r_active_pt;
            end
        end else if ((r_state == S_IDLE) && r_pending) begin
            w_active_nxt    = r_shadow;
            w_active_pt_nxt = r_shadow_pt;
        end else begin
            w_active_nxt    = r_active;
            w_active_pt_nxt = r_active_pt;
        end
    end

    // Blanking and digit mux for the slot about to be presented.
    always_comb begin
        w_ext                       = '0;
        w_ext[4*NUM_DIGITS-1:0]     = w_active_nxt;
        w_mask                      = '0;
        w_code_nxt                  = CODE_BLANK;
        w_point_nxt                 = 1'b0;
        w_anode_nxt                 = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (BLANK_LEADING != 0) begin
                w_mask[i] = lead_zero_blank(w_ext, i, NUM_DIGITS);
            end else begin
                w_mask[i] = 1'b0;
            end
        end
        if (w_state_nxt == S_IDLE) begin
            w_code_nxt  = CODE_BLANK;
            w_point_nxt = 1'b0;
        end else begin
            w_code_nxt  = w_mask[w_sel_nxt] ? CODE_BLANK : w_active_nxt[4*w_sel_nxt +: 4];
            w_point_nxt = w_active_pt_nxt[w_sel_nxt];
        end
        if (w_state_nxt == S_ON) begin
            w_anode_nxt = ~(NUM_DIGITS'(1) << w_sel_nxt);
        end else begin
            w_anode_nxt = '1;
        end
    end

    // Scan state and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Shadow capture, pending flag and active digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= {NUM_DIGITS{CODE_BLANK}};
            r_shadow_pt <= '0;
            r_active    <= {NUM_DIGITS{CODE_BLANK}};
            r_active_pt <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_active    <= w_active_nxt;
            r_active_pt <= w_active_pt_nxt;
            if (bus.load) begin
                r_shadow    <= bus.digits_in;
                r_shadow_pt <= bus.point_in;
                r_pending   <= !w_wrap;
            end else if (w_wrap || (r_state == S_IDLE)) begin
                r_pending   <= 1'b0;
            end else begin
                r_pending   <= r_pending;
            end
        end
    end

    // Registered decoder and anode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code       <= CODE_BLANK;
            r_point      <= 1'b0;
            r_anode_n    <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_code       <= w_code_nxt;
            r_point      <= w_point_nxt;
            r_anode_n    <= w_anode_nxt;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.code_out       = r_code;
    assign bus.show_point_out = r_point;
    assign bus.anode_n        = r_anode_n;
    assign bus.digit_sel      = r_sel;
    assign bus.frame_done     = r_frame_done;

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexes a row of seven-segment digits that share one SevenSegmentDecoder instance. Each cycle it drives the decoder with one 4-bit digit code and its point flag, and drives the active-low anode enables. It holds a shadow/active register pair so the calculator core can update the display without tearing. It also applies leading-zero blanking and a ghosting guard interval. It sits between the calculator result/entry logic and the decoder/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (index NUM_DIGITS-1 = most significant, leftmost)
REFRESH_DIV, 100000, clock cycles per digit slot (>= GUARD+1)
GUARD, 16, cycles at the start of each slot with all anodes off (>= 1)
BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all digits

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning; 0 = display dark, timers held
load  in  1  one-cycle strobe; captures digits_in/point_in into shadow
digits_in  in  4*NUM_DIGITS  digit codes, nibble i = digit i; 0-9 numeric, 10 dash, 15 blank
point_in  in  NUM_DIGITS  bit i = 1 lights decimal point of digit i
code_out  out  4  digit code to decoder "in"
show_point_out  out  1  to decoder "showPoint"; 1 = point lit
anode_n  out  NUM_DIGITS  active-low digit enables, at most one bit 0
digit_sel  out  clog2(NUM_DIGITS)  index of digit currently addressed
frame_done  out  1  one-cycle pulse when digit NUM_DIGITS-1 slot ends

Behaviour:
- Reset (async, rst_n=0):
  - anode_n all 1s, code_out=15, show_point_out=0, digit_sel=0, frame_done=0.
  - Shadow and active digits = 15, points = 0, pending=0, slot counter=0.
- All outputs are registered. Reset release takes effect on the first clk edge with rst_n=1.
- FSM states: IDLE, GUARD, ON.
  - IDLE: anode_n all 1s, counter=0, digit_sel=0. Enters GUARD on the cycle after enable=1 is sampled.
  - GUARD: slot counter 0..GUARD-1. Anodes all off. code_out and show_point_out already present the selected digit.
  - ON: counter GUARD..REFRESH_DIV-1. anode_n[digit_sel]=0.
  - At counter==REFRESH_DIV-1: counter returns to 0, state goes to GUARD, and digit_sel increments.
  - digit_sel wraps from NUM_DIGITS-1 to 0. On that wrap edge frame_done=1 for exactly one cycle.
  - enable=0 in any state: next cycle IDLE, anodes off, counter/digit_sel cleared, no frame_done.
- Shadow/commit:
  - load=1 copies inputs to shadow and sets pending.
  - A repeated load while pending overwrites the shadow.
  - Commit shadow->active on the frame wrap edge and clear pending.
  - If load coincides with the wrap edge, the load data is committed directly and pending stays 0.
  - In IDLE, pending commits on the cycle after load.
  - Outputs always derive from active, never from shadow.
- Blanking (BLANK_LEADING=1):
  - Digit i with active value 0 is shown as 15 when every more-significant digit is 0 or 15.
  - Dash (10) counts as significant.
  - Digit 0 is never blanked.
  - The point of a blanked digit is still shown per point_in.
- Codes 11-14 are passed through unchanged; the decoder blanks them.
- Counter width is clog2(REFRESH_DIV); no other arithmetic.
- Mid-slot reset: immediate dark, restart from digit 0 after release with enable=1.

Decomposition:
- Shared package display_pkg:
  - CODE_DASH=4'd10, CODE_BLANK=4'd15
  - scan_state_t enum {IDLE, GUARD, ON}
  - function computing the leading-zero blank mask from the active digit vector
- Sub-module refresh_timer (params REFRESH_DIV, GUARD; ports clk, rst_n, run):
  - outputs in_guard and slot_end
  - holds the slot counter; cleared when run=0
- Top-level holds the FSM, digit_sel, registers, and blanking/mux logic.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
- Reset/idle: rst_n=0 then 1 with enable=0, 50 cycles -> anode_n=4'b1111, code_out=15, frame_done never 1.
- Scan order: load digits 4,3,2,1 (digit3..0), enable=1 -> digit_sel 0,1,2,3 repeating, each for 8 cycles.
  - anode_n low for 6 cycles of each slot; first pattern 4'b1110, code_out=1.
  - frame_done pulses every 32 cycles.
- Blanking: load digits 0,0,7,0 (digit3..0) -> slot codes digit0=0, digit1=7, digit2=15, digit3=15.
  - Load 10,0,0,5 -> dash and the zeros shown (10,0,0,5).
- Tear-free commit: load new value mid-frame -> old codes persist until the frame_done edge; new codes appear from the next digit0 slot.
  - Load on the wrap cycle -> committed at that edge.
- Point: point_in=4'b0100 with digits 1,2,3,4 -> show_point_out=1 only while digit_sel=2.
- Enable drop/reset mid-ON: enable=0 during digit 2 ON -> next cycle anode_n=4'b1111, digit_sel=0.
  - Async rst_n pulse mid-slot clears outputs without a clock edge.
